// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
// Mode encoding, default geometry and counter direction live here.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int DEF_CH_N  = 4;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_PRE_W = 8;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider producing a one-clock tick every prescale_i+1 clocks.
// clr_i holds the divider at zero and suppresses the tick.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic [PRE_W-1:0] prescale_i,
    output logic             tick_o
);

    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] pre_cnt_r;

    // >= rather than == so a prescale lowered below the running count wraps at once
    assign tick_o = !clr_i && (pre_cnt_r >= prescale_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_cnt_r <= '0;
        end else if (clr_i || tick_o) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with shared edge/center-aligned counter and
// double-buffered mode/period/duty applied only at period boundaries.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int CH_N  = DEF_CH_N,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  mode_i,
    input  logic [PRE_W-1:0]      prescale_i,
    input  logic [CNT_W-1:0]      period_i,
    input  logic [CH_N*CNT_W-1:0] duty_i,
    input  logic                  load_i,
    output logic                  load_pend_o,
    output logic [CH_N-1:0]       pwm_o,
    output logic                  period_end_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                  mode_act_r,   mode_pend_r;
    logic [CNT_W-1:0]      period_act_r, period_pend_r;
    logic [CH_N*CNT_W-1:0] duty_act_r,   duty_pend_r;
    logic                  load_pend_r;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt;
    dir_e                  dir_r, dir_nxt;
    logic                  en_q_r;
    logic [CH_N-1:0]       pwm_r, cmp_w;
    logic                  period_end_r;
    logic                  tick_w, boundary_w, en_rise_w, apply_w;

    // The enable rising clock is a reload-only clock: the divider is held so the counter stays at 0
    assign en_rise_w = en_i && !en_q_r;
    assign apply_w   = boundary_w || en_rise_w;

    pwm_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (!en_i || en_rise_w),
        .prescale_i (prescale_i),
        .tick_o     (tick_w)
    );

    always_comb begin
        cnt_nxt    = cnt_r;
        dir_nxt    = dir_r;
        boundary_w = 1'b0;
        if (tick_w) begin
            if (mode_act_r == MODE_EDGE) begin
                dir_nxt = DIR_UP;
                if (cnt_r >= period_act_r) begin
                    cnt_nxt    = '0;
                    boundary_w = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end else if (dir_r == DIR_UP) begin
                if (cnt_r < period_act_r) begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end else if (cnt_r <= CNT_ONE) begin
                    // period 0 or 1: the top is already adjacent to 0
                    cnt_nxt    = '0;
                    boundary_w = 1'b1;
                end else begin
                    cnt_nxt = cnt_r - CNT_ONE;
                    dir_nxt = DIR_DOWN;
                end
            end else if (cnt_r <= CNT_ONE) begin
                cnt_nxt    = '0;
                dir_nxt    = DIR_UP;
                boundary_w = 1'b1;
            end else begin
                cnt_nxt = cnt_r - CNT_ONE;
            end
        end
    end

    always_comb begin
        cmp_w = '0;
        for (int k = 0; k < CH_N; k++) begin
            cmp_w[k] = cnt_r < duty_act_r[k*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r        <= '0;
            dir_r        <= DIR_UP;
            en_q_r       <= 1'b0;
            pwm_r        <= '0;
            period_end_r <= 1'b0;
        end else begin
            en_q_r       <= en_i;
            period_end_r <= boundary_w;
            pwm_r        <= cmp_w & {CH_N{en_i}};
            if (!en_i) begin
                cnt_r <= '0;
                dir_r <= DIR_UP;
            end else begin
                cnt_r <= cnt_nxt;
                dir_r <= dir_nxt;
            end
        end
    end

    // A load landing on an apply clock bypasses the pending stage entirely
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_act_r    <= MODE_EDGE;
            period_act_r  <= '0;
            duty_act_r    <= '0;
            mode_pend_r   <= MODE_EDGE;
            period_pend_r <= '0;
            duty_pend_r   <= '0;
            load_pend_r   <= 1'b0;
        end else if (apply_w) begin
            load_pend_r <= 1'b0;
            if (load_i) begin
                mode_act_r   <= mode_i;
                period_act_r <= period_i;
                duty_act_r   <= duty_i;
            end else if (load_pend_r) begin
                mode_act_r   <= mode_pend_r;
                period_act_r <= period_pend_r;
                duty_act_r   <= duty_pend_r;
            end
        end else if (load_i) begin
            mode_pend_r   <= mode_i;
            period_pend_r <= period_i;
            duty_pend_r   <= duty_i;
            load_pend_r   <= 1'b1;
        end
    end

    assign pwm_o        = pwm_r;
    assign period_end_o = period_end_r;
    assign load_pend_o  = load_pend_r;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch: each period_end_o closes a window whose
// length and per-channel high-clock counts are compared against queued expectations.
module tb_pwm_multi_ch;

    localparam int CH_N  = 4;
    localparam int CNT_W = 8;
    localparam int PRE_W = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_n_i = 1'b0;
    logic                  en_i = 1'b0;
    logic                  mode_i = 1'b0;
    logic [PRE_W-1:0]      prescale_i = '0;
    logic [CNT_W-1:0]      period_i = '0;
    logic [CH_N*CNT_W-1:0] duty_i = '0;
    logic                  load_i = 1'b0;
    logic                  load_pend_o;
    logic [CH_N-1:0]       pwm_o;
    logic                  period_end_o;

    typedef struct packed {
        logic [15:0]            len;
        logic [CH_N-1:0][15:0]  high;
    } win_t;

    win_t expQ[$];
    int   tests = 0;
    int   failures = 0;
    int   winLen = 0;
    int   winHigh [CH_N];

    pwm_multi_ch #(.CH_N(CH_N), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .mode_i       (mode_i),
        .prescale_i   (prescale_i),
        .period_i     (period_i),
        .duty_i       (duty_i),
        .load_i       (load_i),
        .load_pend_o  (load_pend_o),
        .pwm_o        (pwm_o),
        .period_end_o (period_end_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectWindow(input int len, input int h0, input int h1, input int h2, input int h3);
        win_t w;
        w.len     = 16'(len);
        w.high[0] = 16'(h0);
        w.high[1] = 16'(h1);
        w.high[2] = 16'(h2);
        w.high[3] = 16'(h3);
        expQ.push_back(w);
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #2;
    endtask

    // Drives a configuration for one clock with load_i high
    task automatic applyStimulus(input logic mode, input int period, input int prescale,
                                 input int d0, input int d1, input int d2, input int d3);
        nextCycle();
        mode_i     = mode;
        period_i   = CNT_W'(period);
        prescale_i = PRE_W'(prescale);
        duty_i     = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
        load_i     = 1'b1;
        nextCycle();
        load_i     = 1'b0;
    endtask

    // Load seen by the DUT on the clock edge off+1 edges after the last period_end sample
    task automatic loadAt(input int off, input int d0, input int d1, input int d2, input int d3);
        repeat (off - 1) nextCycle();
        applyStimulus(1'b0, 9, 0, d0, d1, d2, d3);
    endtask

    task automatic waitPe(input string name);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!period_end_o && n < 200);
        checkOutput(name, period_end_o, 1);
    endtask

    task automatic enableRun(input logic pendBefore);
        nextCycle();
        en_i = 1'b1;
        @(negedge clk_i);
        checkOutput("pend_before_rise", load_pend_o, pendBefore);
        @(negedge clk_i);
        checkOutput("pend_after_rise", load_pend_o, 0);
    endtask

    task automatic disableRun();
        nextCycle();
        en_i = 1'b0;
        nextCycle();
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("disabled_pwm", pwm_o, 0);
            checkOutput("disabled_period_end", period_end_o, 0);
        end
    endtask

    // Monitor: accumulate per-window activity and score it at every period_end_o
    always @(negedge clk_i) begin
        if (!rst_n_i || !en_i) begin
            winLen = 0;
            foreach (winHigh[k]) winHigh[k] = 0;
        end else begin
            winLen++;
            foreach (winHigh[k]) winHigh[k] += int'(pwm_o[k]);
            if (period_end_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_period_end", 1, 0);
                end else begin
                    win_t e;
                    e = expQ.pop_front();
                    checkOutput("win_len", winLen, 32'(e.len));
                    for (int k = 0; k < CH_N; k++)
                        checkOutput($sformatf("win_high_ch%0d", k), winHigh[k], 32'(e.high[k]));
                end
                winLen = 0;
                foreach (winHigh[k]) winHigh[k] = 0;
            end
        end
    end

    // First window after enable spans the enable clock, the reload clock and one full period;
    // the reload clock compares counter 0 against the duty active before the reload.
    initial begin
        repeat (3) @(negedge clk_i);
        checkOutput("reset_pwm", pwm_o, 0);
        checkOutput("reset_period_end", period_end_o, 0);
        checkOutput("reset_pend", load_pend_o, 0);
        nextCycle();
        rst_n_i = 1'b1;

        // Edge mode, period 9, duties 0/3/10/255
        applyStimulus(1'b0, 9, 0, 0, 3, 10, 255);
        enableRun(1'b1);
        expectWindow(12, 0, 3, 10, 10);
        expectWindow(10, 0, 3, 10, 10);
        waitPe("pe_edge_1");
        waitPe("pe_edge_2");
        disableRun();

        // Center mode, period 4: counter 0,1,2,3,4,3,2,1; duty 2 is high on 1,0,1
        applyStimulus(1'b1, 4, 0, 0, 2, 4, 5);
        enableRun(1'b1);
        expectWindow(10, 0, 4, 8, 9);
        expectWindow(8, 0, 3, 7, 8);
        expectWindow(8, 0, 3, 7, 8);
        repeat (3) waitPe("pe_center");
        disableRun();

        // Prescale 2, edge period 3: 12-clock periods
        applyStimulus(1'b0, 3, 2, 1, 2, 0, 4);
        enableRun(1'b1);
        expectWindow(14, 3, 7, 1, 13);
        expectWindow(12, 3, 6, 0, 12);
        expectWindow(12, 3, 6, 0, 12);
        repeat (3) waitPe("pe_prescale");
        disableRun();

        // Shadow loading: mid-period, on the boundary, and double load
        applyStimulus(1'b0, 9, 0, 5, 3, 10, 0);
        enableRun(1'b1);
        expectWindow(12, 6, 4, 10, 1);
        expectWindow(10, 5, 3, 10, 0);
        waitPe("pe_load_1");
        waitPe("pe_load_2");
        expectWindow(10, 5, 3, 10, 0);
        loadAt(3, 1, 3, 10, 0);
        @(negedge clk_i);
        checkOutput("pend_mid_load", load_pend_o, 1);
        waitPe("pe_load_3");
        checkOutput("pend_cleared", load_pend_o, 0);
        expectWindow(10, 1, 3, 10, 0);
        loadAt(9, 7, 3, 10, 0);
        waitPe("pe_load_4");
        checkOutput("pend_direct_apply", load_pend_o, 0);
        expectWindow(10, 7, 3, 10, 0);
        loadAt(2, 2, 3, 10, 0);
        @(negedge clk_i);
        checkOutput("pend_first_of_two", load_pend_o, 1);
        loadAt(2, 6, 3, 10, 0);
        @(negedge clk_i);
        checkOutput("pend_second_of_two", load_pend_o, 1);
        waitPe("pe_load_5");
        checkOutput("pend_after_double", load_pend_o, 0);
        expectWindow(10, 6, 3, 10, 0);
        waitPe("pe_load_6");
        disableRun();

        // Restart, then reset mid-period
        enableRun(1'b0);
        expectWindow(12, 7, 4, 11, 0);
        waitPe("pe_restart");
        repeat (4) nextCycle();
        rst_n_i = 1'b0;
        #1;
        checkOutput("midreset_pwm", pwm_o, 0);
        checkOutput("midreset_period_end", period_end_o, 0);
        checkOutput("midreset_pend", load_pend_o, 0);
        en_i = 1'b0;
        nextCycle();
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("postreset_pwm", pwm_o, 0);

        // Pending load survives a disable and applies on the enable rise
        applyStimulus(1'b0, 9, 0, 2, 0, 0, 9);
        enableRun(1'b1);
        expectWindow(12, 2, 0, 0, 9);
        waitPe("pe_after_reset");
        loadAt(3, 4, 0, 0, 9);
        @(negedge clk_i);
        checkOutput("pend_before_disable", load_pend_o, 1);
        disableRun();
        checkOutput("pend_while_disabled", load_pend_o, 1);
        enableRun(1'b1);
        expectWindow(12, 5, 0, 0, 10);
        expectWindow(10, 4, 0, 0, 9);
        waitPe("pe_reenable_1");
        waitPe("pe_reenable_2");
        disableRun();

        checkOutput("queue_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
